pattern_scheduler: RTL and testbench
====================================

Name: pattern_scheduler

Overview:
- Frame-level controller for the monitor tester. It selects which test pattern the pixel datapath renders, from button presses or an auto-advance timer.
- Pattern changes are deferred to the start of vertical blanking, taken from the vertical timing generator's active-region flag, so no torn frame is ever displayed.
- Optionally forces black for a fixed number of frames after each change.
- Sits between the sync generators and the pattern/colour mux.

Parameters:
- NUM_PATTERNS, 8, number of selectable patterns (2..2^PAT_W).
- PAT_W, 3, width of pattern_sel.
- AUTO_FRAMES, 120, frames per pattern in auto mode (2 s at 60 Hz); range 1..2^CNT_W-1.
- BLANK_FRAMES, 2, frames of forced black after a switch; 0 disables blanking.
- CNT_W, 8, width of the frame counters.

Ports:
- clock25MHz  in  1  pixel clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- isVerticalActive  in  1  vertical active-region flag from the vertical timing generator. Its falling edge marks vblank start.
- btn_next  in  1  raw asynchronous level, already debounced externally; rising edge = advance request.
- btn_prev  in  1  raw asynchronous level, already debounced externally; rising edge = step-back request.
- auto_en  in  1  level; enables auto-advance.
- pattern_sel  out  PAT_W  current pattern index, registered.
- force_blank  out  1  datapath must output black while high.
- switch_pulse  out  1  one-cycle pulse on the cycle pattern_sel changes.
- busy  out  1  high in PENDING or BLANK.

Behaviour:
- Reset (async, active-high) values:
  - pattern_sel=0, force_blank=0, switch_pulse=0, busy=0, state=RUN.
  - auto_cnt=0, blank_cnt=0, dir=0.
  - Both 2-flop button synchronisers = 0; vsync-edge register = 0.
- Buttons:
  - Each passes through a 2-flop synchroniser, then a registered rising-edge detect.
  - Raw rise before edge k gives the request pulse after edge k+2. The FSM acts on edge k+3.
  - A button held through reset release counts as one press.
- vblank_start = registered isVerticalActive AND NOT current isVerticalActive. It is one cycle long.
- RUN state:
  - busy=0, force_blank=0.
  - next_req -> dir=next, go PENDING. Otherwise prev_req -> dir=prev, go PENDING.
  - Simultaneous next and prev resolve to next.
  - If auto_en=1, auto_cnt increments on each vblank_start. When auto_cnt reaches AUTO_FRAMES-1 and vblank_start is high, auto_cnt clears, dir=next and the state goes to PENDING. Switching happens on the following vblank_start.
  - A manual request in the same cycle as the auto terminal count wins; auto_cnt clears either way.
  - auto_en=0 holds auto_cnt at 0.
- PENDING state:
  - busy=1. Further requests are dropped, not queued.
  - On vblank_start, pattern_sel updates in the same cycle's register update:
    - next: NUM_PATTERNS-1 -> 0, else +1.
    - prev: 0 -> NUM_PATTERNS-1, else -1.
  - In that same cycle: switch_pulse=1, auto_cnt=0, blank_cnt=0.
  - Then go BLANK (force_blank=1 from that edge) if BLANK_FRAMES>0, else RUN.
  - A vblank_start in the cycle that enters PENDING is not consumed; the switch waits for the next one.
- BLANK state:
  - busy=1, force_blank=1. Requests are dropped.
  - blank_cnt increments on each vblank_start.
  - On the vblank_start where blank_cnt = BLANK_FRAMES-1: go RUN, force_blank=0 from that edge.
  - Result: exactly BLANK_FRAMES full active frames are black.
- auto_en dropping mid-PENDING does not cancel an already-latched auto request.
- Reset asserted mid-operation returns all state to reset values immediately. pattern_sel reverts to 0.
- All outputs are registered; no combinational input-to-output path.

Decomposition:
- Shared package (vga_pkg): FSM state encoding (RUN, PENDING, BLANK), direction encoding, and VGA frame constants shared with the timing generators (480 active lines, 60 Hz frame rate).
- One natural sub-module: btn_edge_sync (2-flop synchroniser plus rising-edge pulse), instantiated twice.

Test Plan:
- Reset then pulse btn_next for 5 cycles mid-frame -> busy=1 after 3 edges. pattern_sel 0->1 with switch_pulse on the vblank_start cycle. force_blank high for exactly 2 active frames, then busy=0.
- Reset, btn_prev once -> pattern_sel wraps 0->7 at the next vblank_start. Eight btn_next presses, each separated by 3 frames -> pattern_sel ends at 7 after passing 0..7.
- btn_next and btn_prev rising on the same cycle -> single next step, pattern_sel 0->1. A second btn_next during PENDING is dropped, so pattern_sel=1, not 2.
- auto_en=1, AUTO_FRAMES=4, BLANK_FRAMES=0 -> pattern_sel increments once every 5 vblank_starts (4 counted + 1 pending). switch_pulse high one cycle each time; force_blank stays 0.
- Assert reset during BLANK with pattern_sel=3 -> outputs immediately 0 (pattern_sel=0, force_blank=0, busy=0). No switch_pulse after release.
- isVerticalActive held high for 3 frame times, then falling -> exactly one vblank_start. A pending switch completes on that edge only.

Source files
------------

// File: rtl/vga_pkg.sv
// Definitions shared by the frame-level controllers and the VGA timing generators:
// scheduler state and direction encodings plus the frame geometry constants.
package vga_pkg;

   localparam int V_ACTIVE_LINES = 480;
   localparam int FRAME_RATE_HZ  = 60;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_PENDING = 2'd1,
      ST_BLANK   = 2'd2
   } sched_state_t;

   typedef enum logic {
      DIR_NEXT = 1'b0,
      DIR_PREV = 1'b1
   } dir_t;

endpackage

// File: rtl/btn_edge_sync.sv
// Brings an externally debounced button level into the pixel clock domain and
// emits a one-cycle registered pulse on each rising edge.
module btn_edge_sync (
   input  logic clock25MHz,
   input  logic reset,
   input  logic btn,
   output logic req
);

   logic meta;
   logic sync;
   logic sync_q;

   always_ff @(posedge clock25MHz or posedge reset) begin
      if (reset) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_q <= 1'b0;
         req    <= 1'b0;
      end else begin
         meta   <= btn;
         sync   <= meta;
         sync_q <= sync;
         req    <= sync & ~sync_q;
      end
   end

endmodule

// File: rtl/pattern_scheduler.sv
// Picks the test pattern shown by the pixel datapath; changes are applied only at
// vblank start and may be followed by a fixed number of forced-black frames.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | idle, showing pattern_sel; accepts button/auto requests
// PENDING | request latched, waiting for vblank start to switch
// BLANK   | just switched; forcing black until BLANK_FRAMES frames pass
module pattern_scheduler
   import vga_pkg::*;
#(
   parameter int NUM_PATTERNS = 8,
   parameter int PAT_W        = 3,
   parameter int AUTO_FRAMES  = 2 * FRAME_RATE_HZ,
   parameter int BLANK_FRAMES = 2,
   parameter int CNT_W        = 8
) (
   input  logic             clock25MHz,
   input  logic             reset,
   input  logic             isVerticalActive,
   input  logic             btn_next,
   input  logic             btn_prev,
   input  logic             auto_en,
   output logic [PAT_W-1:0] pattern_sel,
   output logic             force_blank,
   output logic             switch_pulse,
   output logic             busy
);

   localparam logic [PAT_W-1:0] PAT_LAST   = PAT_W'(NUM_PATTERNS - 1);
   localparam logic [CNT_W-1:0] AUTO_LAST  = CNT_W'(AUTO_FRAMES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_FRAMES - 1);

   sched_state_t     state, state_n;
   dir_t             dir, dir_n;
   logic [PAT_W-1:0] pat_n;
   logic [CNT_W-1:0] auto_cnt, auto_cnt_n;
   logic [CNT_W-1:0] blank_cnt, blank_cnt_n;
   logic             force_blank_n, switch_pulse_n, busy_n;
   logic             va_q, vblank_start, auto_tc;
   logic             next_req, prev_req;

   btn_edge_sync u_sync_next (
      .clock25MHz (clock25MHz),
      .reset      (reset),
      .btn        (btn_next),
      .req        (next_req)
   );

   btn_edge_sync u_sync_prev (
      .clock25MHz (clock25MHz),
      .reset      (reset),
      .btn        (btn_prev),
      .req        (prev_req)
   );

   assign vblank_start = va_q & ~isVerticalActive;

   always_comb begin
      state_n        = state;
      dir_n          = dir;
      pat_n          = pattern_sel;
      auto_cnt_n     = auto_cnt;
      blank_cnt_n    = blank_cnt;
      switch_pulse_n = 1'b0;
      auto_tc        = 1'b0;

      if (!auto_en) auto_cnt_n = '0;

      unique case (state)
         ST_RUN: begin
            if (auto_en && vblank_start) begin
               if (auto_cnt == AUTO_LAST) begin
                  auto_cnt_n = '0;
                  auto_tc    = 1'b1;
               end else begin
                  auto_cnt_n = auto_cnt + CNT_W'(1);
               end
            end
            // manual requests take priority over the auto terminal count
            if (next_req) begin
               dir_n   = DIR_NEXT;
               state_n = ST_PENDING;
            end else if (prev_req) begin
               dir_n   = DIR_PREV;
               state_n = ST_PENDING;
            end else if (auto_tc) begin
               dir_n   = DIR_NEXT;
               state_n = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (vblank_start) begin
               if (dir == DIR_NEXT)
                  pat_n = (pattern_sel == PAT_LAST) ? '0 : pattern_sel + PAT_W'(1);
               else
                  pat_n = (pattern_sel == '0) ? PAT_LAST : pattern_sel - PAT_W'(1);
               switch_pulse_n = 1'b1;
               auto_cnt_n     = '0;
               blank_cnt_n    = '0;
               state_n        = (BLANK_FRAMES > 0) ? ST_BLANK : ST_RUN;
            end
         end
         ST_BLANK: begin
            if (vblank_start) begin
               if (blank_cnt == BLANK_LAST) state_n = ST_RUN;
               else                         blank_cnt_n = blank_cnt + CNT_W'(1);
            end
         end
         default: state_n = ST_RUN;
      endcase

      busy_n        = (state_n != ST_RUN);
      force_blank_n = (state_n == ST_BLANK);
   end

   always_ff @(posedge clock25MHz or posedge reset) begin
      if (reset) begin
         state        <= ST_RUN;
         dir          <= DIR_NEXT;
         pattern_sel  <= '0;
         auto_cnt     <= '0;
         blank_cnt    <= '0;
         force_blank  <= 1'b0;
         switch_pulse <= 1'b0;
         busy         <= 1'b0;
         va_q         <= 1'b0;
      end else begin
         state        <= state_n;
         dir          <= dir_n;
         pattern_sel  <= pat_n;
         auto_cnt     <= auto_cnt_n;
         blank_cnt    <= blank_cnt_n;
         force_blank  <= force_blank_n;
         switch_pulse <= switch_pulse_n;
         busy         <= busy_n;
         va_q         <= isVerticalActive;
      end
   end

endmodule

// File: tb/tb_pattern_scheduler.sv
// Bench for pattern_scheduler: two instances (default and fast-auto/no-blank) checked
// every cycle against an event-level model, plus table vectors and directed sequences.
module tb_pattern_scheduler;

   localparam int ACT   = 20;
   localparam int FRAME = 26;
   localparam int NP    = 8;

   logic clock25MHz = 1'b0;
   logic reset      = 1'b1;
   logic va         = 1'b0;
   logic btn_next   = 1'b0;
   logic btn_prev   = 1'b0;
   logic auto_en    = 1'b0;
   logic va_hold    = 1'b0;
   int   fcnt       = 0;

   logic [2:0] ps0, ps1;
   logic       fb0, sw0, bz0, fb1, sw1, bz1;

   int chk_cnt = 0;
   int pass_cnt = 0;
   int fail_prints = 0;

   always #5 clock25MHz = ~clock25MHz;

   pattern_scheduler dut (
      .clock25MHz(clock25MHz), .reset(reset), .isVerticalActive(va),
      .btn_next(btn_next), .btn_prev(btn_prev), .auto_en(auto_en),
      .pattern_sel(ps0), .force_blank(fb0), .switch_pulse(sw0), .busy(bz0));

   pattern_scheduler #(.AUTO_FRAMES(4), .BLANK_FRAMES(0)) dut_a (
      .clock25MHz(clock25MHz), .reset(reset), .isVerticalActive(va),
      .btn_next(btn_next), .btn_prev(btn_prev), .auto_en(auto_en),
      .pattern_sel(ps1), .force_blank(fb1), .switch_pulse(sw1), .busy(bz1));

   // frame generator: ACT active cycles then FRAME-ACT blanking cycles
   always @(negedge clock25MHz) begin
      fcnt = (fcnt + 1) % FRAME;
      va   = va_hold || (fcnt < ACT);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else begin
         if (fail_prints < 40)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
         fail_prints++;
      end
   endtask

   // Event-level reference: buttons as sample histories, blanking as frames left.
   typedef struct {
      logic [7:0] hn;
      logic [7:0] hp;
      logic       va_prev;
      logic       vb;
      int         pat;
      bit         pending;
      bit         go_back;
      int         blank_left;
      int         frames;
      bit         sw;
   } model_t;

   function automatic model_t mstep(input model_t m, input logic rst, input logic v,
                                    input logic bn, input logic bp, input logic ae,
                                    input int af, input int bf);
      model_t r;
      logic nreq, preq;
      bit tc;
      r = m;
      if (rst) begin
         r = '{default: 0};
         return r;
      end
      r.hn      = {m.hn[6:0], bn};
      r.hp      = {m.hp[6:0], bp};
      r.vb      = m.va_prev & ~v;
      r.va_prev = v;
      nreq      = r.hn[3] & ~r.hn[4];
      preq      = r.hp[3] & ~r.hp[4];
      r.sw      = 0;
      tc        = 0;
      if (m.pending) begin
         if (r.vb) begin
            r.pat        = m.go_back ? (m.pat + NP - 1) % NP : (m.pat + 1) % NP;
            r.sw         = 1;
            r.frames     = 0;
            r.pending    = 0;
            r.blank_left = bf;
         end
      end else if (m.blank_left > 0) begin
         if (r.vb) r.blank_left = m.blank_left - 1;
      end else begin
         if (!ae) r.frames = 0;
         else if (r.vb) begin
            r.frames = m.frames + 1;
            if (r.frames == af) begin
               r.frames = 0;
               tc = 1;
            end
         end
         if (nreq || preq) begin
            r.pending = 1;
            r.go_back = !nreq;
         end else if (tc) begin
            r.pending = 1;
            r.go_back = 0;
         end
      end
      return r;
   endfunction

   function automatic logic [5:0] mexp(input model_t m);
      return {3'(m.pat), m.blank_left > 0, m.sw, m.pending || (m.blank_left > 0)};
   endfunction

   model_t m0 = '{default: 0};
   model_t m1 = '{default: 0};
   logic   vb_seen = 1'b0;

   always @(posedge clock25MHz) begin
      m0 = mstep(m0, reset, va, btn_next, btn_prev, auto_en, 120, 2);
      m1 = mstep(m1, reset, va, btn_next, btn_prev, auto_en, 4, 0);
      vb_seen = m0.vb;
      #1;
      check("cycle_default", {ps0, fb0, sw0, bz0}, mexp(m0));
      check("cycle_auto4",   {ps1, fb1, sw1, bz1}, mexp(m1));
   end

   task automatic wait_vb(input string name);
      bit ok;
      ok = 0;
      for (int i = 0; i < 4 * FRAME; i++) begin
         @(posedge clock25MHz);
         #1;
         if (vb_seen) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         chk_cnt++;
         $display("FAIL %s: no vblank_start within %0d cycles, required one", name, 4 * FRAME);
      end
   endtask

   task automatic do_reset();
      @(negedge clock25MHz);
      reset    = 1'b1;
      btn_next = 1'b0;
      btn_prev = 1'b0;
      auto_en  = 1'b0;
      va_hold  = 1'b0;
      repeat (2) @(negedge clock25MHz);
      reset = 1'b0;
   endtask

   task automatic press(input logic n, input logic p);
      @(negedge clock25MHz);
      btn_next = n;
      btn_prev = p;
      repeat (4) @(negedge clock25MHz);
      btn_next = 1'b0;
      btn_prev = 1'b0;
   endtask

   task automatic press_settle(input logic n, input logic p);
      press(n, p);
      repeat (3) wait_vb("settle_vb");
   endtask

   typedef struct {
      int         prevs;
      int         nexts;
      logic [2:0] exp_pat;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int swc;
      vecs[0] = '{1, 8, 3'd7};
      vecs[1] = '{0, 3, 3'd3};
      vecs[2] = '{2, 1, 3'd7};
      vecs[3] = '{3, 5, 3'd2};
      vecs[4] = '{0, 9, 3'd1};

      repeat (3) @(negedge clock25MHz);
      check("reset_state", {ps0, fb0, sw0, bz0}, 6'd0);
      reset = 1'b0;

      // single press: request latency, switch at vblank, two black frames
      wait_vb("t1_sync");
      repeat (10) @(negedge clock25MHz);
      btn_next = 1'b1;
      repeat (3) @(posedge clock25MHz);
      #1 check("t1_busy_before_k3", bz0, 1'b0);
      @(posedge clock25MHz);
      #1 check("t1_busy_at_k3", bz0, 1'b1);
      repeat (2) @(negedge clock25MHz);
      btn_next = 1'b0;
      wait_vb("t1_switch");
      check("t1_switch", {ps0, fb0, sw0, bz0}, {3'd1, 1'b1, 1'b1, 1'b1});
      @(posedge clock25MHz);
      #1 check("t1_pulse_one_cycle", sw0, 1'b0);
      wait_vb("t1_blank1");
      check("t1_blank_after_frame1", {fb0, bz0}, 2'b11);
      wait_vb("t1_blank2");
      check("t1_run_after_frame2", {fb0, bz0}, 2'b00);

      // table vectors: prev presses then next presses from reset
      for (int v = 0; v < 5; v++) begin
         do_reset();
         for (int i = 0; i < vecs[v].prevs; i++) press_settle(1'b0, 1'b1);
         for (int i = 0; i < vecs[v].nexts; i++) press_settle(1'b1, 1'b0);
         check("table_pat", ps0, vecs[v].exp_pat);
         check("table_pat_noblank", ps1, vecs[v].exp_pat);
      end

      // simultaneous next+prev resolves to next; a press during PENDING is dropped
      do_reset();
      wait_vb("t3_sync");
      @(negedge clock25MHz);
      btn_next = 1'b1;
      btn_prev = 1'b1;
      repeat (3) @(negedge clock25MHz);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      repeat (2) @(negedge clock25MHz);
      btn_next = 1'b1;
      repeat (3) @(negedge clock25MHz);
      btn_next = 1'b0;
      repeat (4) @(negedge clock25MHz);
      check("t3_pending", {ps0, bz0}, {3'd0, 1'b1});
      wait_vb("t3_switch");
      check("t3_switch_next", ps0, 3'd1);
      repeat (3) wait_vb("t3_settle");
      check("t3_dropped", {ps0, bz0}, {3'd1, 1'b0});

      // auto-advance on the AUTO_FRAMES=4, BLANK_FRAMES=0 instance
      do_reset();
      wait_vb("t4_sync");
      @(negedge clock25MHz);
      auto_en = 1'b1;
      for (int r = 0; r < 3; r++) begin
         repeat (4) wait_vb("t4_count");
         check("t4_hold_pending", {ps1, bz1}, {3'(r), 1'b1});
         wait_vb("t4_switch");
         check("t4_switch", {ps1, fb1, sw1}, {3'(r + 1), 1'b0, 1'b1});
      end
      @(negedge clock25MHz);
      auto_en = 1'b0;

      // reset asserted during BLANK with pattern 3
      do_reset();
      press_settle(1'b1, 1'b0);
      press_settle(1'b1, 1'b0);
      press(1'b1, 1'b0);
      wait_vb("t5_switch");
      check("t5_in_blank", {ps0, fb0}, {3'd3, 1'b1});
      @(negedge clock25MHz);
      reset = 1'b1;
      #1 check("t5_async_reset", {ps0, fb0, sw0, bz0}, 6'd0);
      repeat (2) @(negedge clock25MHz);
      reset = 1'b0;
      swc = 0;
      repeat (3 * FRAME) begin
         @(posedge clock25MHz);
         #1 if (sw0 || sw1) swc++;
      end
      check("t5_no_pulse_after_reset", swc, 0);

      // long active period: one vblank_start only, pending switch waits for it
      do_reset();
      wait_vb("t6_sync");
      @(negedge clock25MHz);
      va_hold = 1'b1;
      press(1'b1, 1'b0);
      swc = 0;
      repeat (3 * FRAME) begin
         @(posedge clock25MHz);
         #1 if (sw0) swc++;
      end
      check("t6_no_switch_while_active", swc, 0);
      check("t6_still_pending", {ps0, bz0}, {3'd0, 1'b1});
      @(negedge clock25MHz);
      va_hold = 1'b0;
      wait_vb("t6_switch");
      check("t6_switch", {ps0, sw0}, {3'd1, 1'b1});

      // randomized traffic, checked every cycle by the model
      do_reset();
      auto_en = 1'b1;
      for (int c = 0; c < 6000; c++) begin
         @(negedge clock25MHz);
         reset = ($urandom_range(0, 999) == 0);
         if ($urandom_range(0, 39) == 0) btn_next = ~btn_next;
         if ($urandom_range(0, 49) == 0) btn_prev = ~btn_prev;
         if ($urandom_range(0, 399) == 0) auto_en = ~auto_en;
      end
      reset = 1'b0;
      repeat (4) @(negedge clock25MHz);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1);
   end

endmodule
